// File: rtl/sa1_rom_arbiter.sv
// Three-way ROM/SRAM arbiter for SNES, SA-1 and MCU with a fixed-length access cycle.
// SNES always wins; the MCU overtakes the SA-1 once it has been passed over STARVE_LIMIT times.
module sa1_rom_arbiter #(
   parameter int ACCESS_CYCLES = 4,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        snes_req,
   input  logic        sa1_req,
   input  logic        mcu_req,
   input  logic [23:0] snes_addr,
   input  logic [23:0] sa1_addr,
   input  logic [23:0] mcu_addr,
   input  logic        snes_we,
   input  logic        sa1_we,
   input  logic        mcu_we,
   input  logic [7:0]  snes_wrdata,
   input  logic [7:0]  sa1_wrdata,
   input  logic [7:0]  mcu_wrdata,
   output logic        snes_ack,
   output logic        sa1_ack,
   output logic        mcu_ack,
   output logic [7:0]  rd_data,
   output logic [23:0] ROM_ADDR,
   output logic [7:0]  ROM_DATA_OUT,
   input  logic [7:0]  ROM_DATA_IN,
   output logic        ROM_CE_N,
   output logic        ROM_OE_N,
   output logic        ROM_WE_N,
   output logic        busy
);

   localparam int            SW       = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIM      = SW'(STARVE_LIMIT);
   localparam logic [3:0]    CNT_INIT = 4'(ACCESS_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [3:0]    r_cnt, w_cnt_nxt;
   logic [2:0]    r_gnt, w_gnt_nxt;        // {snes, sa1, mcu}
   logic          r_we, w_we_nxt;
   logic [23:0]   r_addr, w_addr_nxt;
   logic [7:0]    r_wdata, w_wdata_nxt;
   logic [SW-1:0] r_streak, w_streak_nxt;
   logic [7:0]    r_rd_data;
   logic [2:0]    r_ack;
   logic          r_ce_n, r_oe_n, r_we_n, r_busy;

   // Next-state, arbitration and request latching.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_gnt_nxt    = r_gnt;
      w_we_nxt     = r_we;
      w_addr_nxt   = r_addr;
      w_wdata_nxt  = r_wdata;
      w_streak_nxt = r_streak;
      case (r_state)
         IDLE: begin
            if (!mcu_req) begin
               w_streak_nxt = {SW{1'b0}};
            end else begin
               w_streak_nxt = r_streak;
            end
            if (snes_req) begin
               w_gnt_nxt   = 3'b100;
               w_addr_nxt  = snes_addr;
               w_we_nxt    = snes_we;
               w_wdata_nxt = snes_wrdata;
            end else if (mcu_req && (!sa1_req || r_streak == LIM)) begin
               w_gnt_nxt    = 3'b001;
               w_addr_nxt   = mcu_addr;
               w_we_nxt     = mcu_we;
               w_wdata_nxt  = mcu_wrdata;
               w_streak_nxt = {SW{1'b0}};
            end else if (sa1_req) begin
               w_gnt_nxt   = 3'b010;
               w_addr_nxt  = sa1_addr;
               w_we_nxt    = sa1_we;
               w_wdata_nxt = sa1_wrdata;
               if (mcu_req && r_streak != LIM) begin
                  w_streak_nxt = r_streak + SW'(1);
               end else begin
                  w_streak_nxt = w_streak_nxt;
               end
            end else begin
               w_gnt_nxt = r_gnt;
            end
            if (snes_req || sa1_req || mcu_req) begin
               w_state_nxt = ACCESS;
               w_cnt_nxt   = CNT_INIT;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         ACCESS: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = DONE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, latched request and registered strobes/acks derived from the next state.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= IDLE;
         r_cnt     <= 4'd0;
         r_gnt     <= 3'b000;
         r_we      <= 1'b0;
         r_addr    <= 24'd0;
         r_wdata   <= 8'd0;
         r_streak  <= {SW{1'b0}};
         r_rd_data <= 8'd0;
         r_ack     <= 3'b000;
         r_ce_n    <= 1'b1;
         r_oe_n    <= 1'b1;
         r_we_n    <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_gnt    <= w_gnt_nxt;
         r_we     <= w_we_nxt;
         r_addr   <= w_addr_nxt;
         r_wdata  <= w_wdata_nxt;
         r_streak <= w_streak_nxt;
         if (r_state == ACCESS && r_cnt == 4'd0 && !r_we) begin
            r_rd_data <= ROM_DATA_IN;
         end
         r_ack  <= (w_state_nxt == DONE) ? r_gnt : 3'b000;
         r_ce_n <= (w_state_nxt != ACCESS);
         r_oe_n <= !(w_state_nxt == ACCESS && !w_we_nxt);
         // Write strobe skips the first and last access cycles for address setup/hold.
         r_we_n <= !(w_state_nxt == ACCESS && w_we_nxt &&
                     w_cnt_nxt != CNT_INIT && w_cnt_nxt != 4'd0);
         r_busy <= (w_state_nxt != IDLE);
      end
   end

   assign snes_ack     = r_ack[2];
   assign sa1_ack      = r_ack[1];
   assign mcu_ack      = r_ack[0];
   assign rd_data      = r_rd_data;
   assign ROM_ADDR     = r_addr;
   assign ROM_DATA_OUT = r_wdata;
   assign ROM_CE_N     = r_ce_n;
   assign ROM_OE_N     = r_oe_n;
   assign ROM_WE_N     = r_we_n;
   assign busy         = r_busy;

endmodule

// File: tb/tb_sa1_rom_arbiter.sv
// Directed bench for sa1_rom_arbiter: reset, read, write, contention, starvation, reset mid-access.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sa1_rom_arbiter;

   logic        CLK, RST_N;
   logic        snes_req, sa1_req, mcu_req;
   logic [23:0] snes_addr, sa1_addr, mcu_addr;
   logic        snes_we, sa1_we, mcu_we;
   logic [7:0]  snes_wrdata, sa1_wrdata, mcu_wrdata;
   logic        snes_ack, sa1_ack, mcu_ack;
   logic [7:0]  rd_data;
   logic [23:0] ROM_ADDR;
   logic [7:0]  ROM_DATA_OUT, ROM_DATA_IN;
   logic        ROM_CE_N, ROM_OE_N, ROM_WE_N, busy;

   int n_tests = 0;
   int n_fail  = 0;

   sa1_rom_arbiter #(.ACCESS_CYCLES(4), .STARVE_LIMIT(4)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .snes_req(snes_req), .sa1_req(sa1_req), .mcu_req(mcu_req),
      .snes_addr(snes_addr), .sa1_addr(sa1_addr), .mcu_addr(mcu_addr),
      .snes_we(snes_we), .sa1_we(sa1_we), .mcu_we(mcu_we),
      .snes_wrdata(snes_wrdata), .sa1_wrdata(sa1_wrdata), .mcu_wrdata(mcu_wrdata),
      .snes_ack(snes_ack), .sa1_ack(sa1_ack), .mcu_ack(mcu_ack),
      .rd_data(rd_data), .ROM_ADDR(ROM_ADDR), .ROM_DATA_OUT(ROM_DATA_OUT),
      .ROM_DATA_IN(ROM_DATA_IN), .ROM_CE_N(ROM_CE_N), .ROM_OE_N(ROM_OE_N),
      .ROM_WE_N(ROM_WE_N), .busy(busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // {CE_N, OE_N, WE_N, busy, snes_ack, sa1_ack, mcu_ack}
   function automatic logic [6:0] vec();
      return {ROM_CE_N, ROM_OE_N, ROM_WE_N, busy, snes_ack, sa1_ack, mcu_ack};
   endfunction

   task automatic test_reset();
      RST_N = 1'b0;
      snes_req = 1'b0; sa1_req = 1'b0; mcu_req = 1'b0;
      snes_addr = 24'd0; sa1_addr = 24'd0; mcu_addr = 24'd0;
      snes_we = 1'b0; sa1_we = 1'b0; mcu_we = 1'b0;
      snes_wrdata = 8'd0; sa1_wrdata = 8'd0; mcu_wrdata = 8'd0;
      ROM_DATA_IN = 8'd0;
      repeat (3) @(negedge CLK);
      n_tests++;
      if (vec() !== 7'b1110000) begin
         n_fail++; $display("FAIL reset_vec got=%b exp=%b", vec(), 7'b1110000);
      end
      n_tests++;
      if (ROM_ADDR !== 24'd0) begin
         n_fail++; $display("FAIL reset_addr got=%h exp=%h", ROM_ADDR, 24'd0);
      end
      n_tests++;
      if (ROM_DATA_OUT !== 8'd0) begin
         n_fail++; $display("FAIL reset_dout got=%h exp=%h", ROM_DATA_OUT, 8'd0);
      end
      n_tests++;
      if (rd_data !== 8'd0) begin
         n_fail++; $display("FAIL reset_rd got=%h exp=%h", rd_data, 8'd0);
      end
      RST_N = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_single_read();
      logic [6:0] exp_v;
      mcu_addr = 24'h012345; mcu_we = 1'b0; mcu_req = 1'b1; ROM_DATA_IN = 8'hA5;
      for (int k = 1; k <= 6; k++) begin
         @(negedge CLK);
         exp_v = (k <= 4) ? 7'b0011000 : (k == 5) ? 7'b1111001 : 7'b1110000;
         n_tests++;
         if (vec() !== exp_v) begin
            n_fail++; $display("FAIL read_vec k=%0d got=%b exp=%b", k, vec(), exp_v);
         end
         if (k == 2) mcu_addr = 24'hFFFFFF;
         if (k == 3 || k == 5) begin
            n_tests++;
            if (ROM_ADDR !== 24'h012345) begin
               n_fail++; $display("FAIL read_addr k=%0d got=%h exp=%h", k, ROM_ADDR, 24'h012345);
            end
         end
         if (k == 5) begin
            n_tests++;
            if (rd_data !== 8'hA5) begin
               n_fail++; $display("FAIL read_data got=%h exp=%h", rd_data, 8'hA5);
            end
            mcu_req = 1'b0;
         end
      end
   endtask

   task automatic test_write();
      logic [6:0] exp_v;
      sa1_addr = 24'hE00010; sa1_we = 1'b1; sa1_wrdata = 8'h5A; sa1_req = 1'b1;
      ROM_DATA_IN = 8'h33;
      for (int k = 1; k <= 6; k++) begin
         @(negedge CLK);
         case (k)
            1, 4:    exp_v = 7'b0111000;
            2, 3:    exp_v = 7'b0101000;
            5:       exp_v = 7'b1111010;
            default: exp_v = 7'b1110000;
         endcase
         n_tests++;
         if (vec() !== exp_v) begin
            n_fail++; $display("FAIL write_vec k=%0d got=%b exp=%b", k, vec(), exp_v);
         end
         if (k == 3) begin
            n_tests++;
            if ({ROM_ADDR, ROM_DATA_OUT} !== {24'hE00010, 8'h5A}) begin
               n_fail++; $display("FAIL write_bus got=%h/%h exp=e00010/5a", ROM_ADDR, ROM_DATA_OUT);
            end
         end
         if (k == 5) sa1_req = 1'b0;
         if (k == 6) begin
            n_tests++;
            if (rd_data !== 8'hA5) begin
               n_fail++; $display("FAIL write_rd_kept got=%h exp=%h", rd_data, 8'hA5);
            end
         end
      end
      sa1_we = 1'b0;
   endtask

   task automatic test_contention();
      logic [2:0]  exp_g [3] = '{3'b100, 3'b010, 3'b001};
      int          exp_at[3] = '{5, 11, 17};
      logic [23:0] exp_a [3] = '{24'h100000, 24'h200000, 24'h300000};
      logic [2:0]  got_g [3];
      int          got_at[3];
      logic [23:0] got_a [3];
      logic [2:0]  acks;
      int          n = 0;
      snes_addr = 24'h100000; sa1_addr = 24'h200000; mcu_addr = 24'h300000;
      ROM_DATA_IN = 8'h11;
      snes_req = 1'b1; sa1_req = 1'b1; mcu_req = 1'b1;
      for (int k = 1; k <= 30 && n < 3; k++) begin
         @(negedge CLK);
         acks = {snes_ack, sa1_ack, mcu_ack};
         if (acks != 3'b000) begin
            n_tests++;
            if (!$onehot(acks)) begin
               n_fail++; $display("FAIL cont_onehot k=%0d got=%b exp=one-hot", k, acks);
            end
            got_g[n] = acks; got_at[n] = k; got_a[n] = ROM_ADDR; n++;
            if (snes_ack) snes_req = 1'b0;
            if (sa1_ack)  sa1_req  = 1'b0;
            if (mcu_ack)  mcu_req  = 1'b0;
         end
      end
      n_tests++;
      if (n != 3) begin
         n_fail++; $display("FAIL cont_count got=%0d exp=3", n);
      end
      for (int i = 0; i < n; i++) begin
         n_tests++;
         if (got_g[i] !== exp_g[i] || got_at[i] != exp_at[i] || got_a[i] !== exp_a[i]) begin
            n_fail++;
            $display("FAIL cont_grant%0d got=%b@%0d/%h exp=%b@%0d/%h", i,
                     got_g[i], got_at[i], got_a[i], exp_g[i], exp_at[i], exp_a[i]);
         end
      end
      snes_req = 1'b0; sa1_req = 1'b0; mcu_req = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_starvation();
      logic [2:0] exp_g [6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b010};
      int         exp_at[6] = '{5, 11, 17, 23, 29, 35};
      logic [2:0] got_g [6];
      int         got_at[6];
      logic [2:0] acks;
      int         n = 0;
      sa1_addr = 24'h000200; mcu_addr = 24'h000300;
      sa1_req = 1'b1; mcu_req = 1'b1;
      for (int k = 1; k <= 45 && n < 6; k++) begin
         @(negedge CLK);
         acks = {snes_ack, sa1_ack, mcu_ack};
         if (acks != 3'b000) begin
            got_g[n] = acks; got_at[n] = k; n++;
         end
      end
      sa1_req = 1'b0; mcu_req = 1'b0;
      n_tests++;
      if (n != 6) begin
         n_fail++; $display("FAIL starve_count got=%0d exp=6", n);
      end
      for (int i = 0; i < n; i++) begin
         n_tests++;
         if (got_g[i] !== exp_g[i] || got_at[i] != exp_at[i]) begin
            n_fail++;
            $display("FAIL starve_grant%0d got=%b@%0d exp=%b@%0d", i,
                     got_g[i], got_at[i], exp_g[i], exp_at[i]);
         end
      end
      @(negedge CLK);
   endtask

   task automatic test_reset_mid_access();
      int ack_at = -1;
      int other  = 0;
      sa1_addr = 24'h000100; sa1_we = 1'b0; sa1_req = 1'b1; ROM_DATA_IN = 8'h77;
      @(negedge CLK);
      n_tests++;
      if (vec() !== 7'b0011000) begin
         n_fail++; $display("FAIL rst_mid_access got=%b exp=%b", vec(), 7'b0011000);
      end
      @(negedge CLK);
      RST_N = 1'b0;
      #1;
      n_tests++;
      if (vec() !== 7'b1110000 || ROM_ADDR !== 24'd0 || rd_data !== 8'd0) begin
         n_fail++;
         $display("FAIL rst_mid_force got=%b/%h/%h exp=1110000/000000/00", vec(), ROM_ADDR, rd_data);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      for (int k = 1; k <= 12 && ack_at < 0; k++) begin
         @(negedge CLK);
         if (snes_ack || mcu_ack) other++;
         if (sa1_ack) begin
            ack_at = k;
            n_tests++;
            if (rd_data !== 8'h77) begin
               n_fail++; $display("FAIL rst_mid_rd got=%h exp=%h", rd_data, 8'h77);
            end
            sa1_req = 1'b0;
         end
      end
      sa1_req = 1'b0;
      n_tests++;
      if (ack_at != 5 || other != 0) begin
         n_fail++; $display("FAIL rst_mid_retry got=ack@%0d other=%0d exp=ack@5 other=0", ack_at, other);
      end
      @(negedge CLK);
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write();
      test_contention();
      test_starvation();
      test_reset_mid_access();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
